// File: rtl/dmem_arbiter_pkg.sv
// rv32_arb_pkg: shared types and constants for the dmem arbiter.
//   state_t    - arbiter FSM state encoding (IDLE/ACCESS/RESP)
//   PORT_CORE  - port index of the rv32 core load/store path
//   PORT_LOAD  - port index of the program/debug loader
package rv32_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester-side and memory-side signals of the dmem arbiter.
//   req0/1, we0/1, addr0/1, wdata0/1 - requests from core (0) and loader (1)
//   ack0/1, rdata0/1                 - registered completion pulse and read data
//   mem_we, mem_addr, mem_wdata      - single-port synchronous memory controls
//   mem_rdata                        - memory read data, valid the cycle after the address edge
//   busy                             - arbiter not idle
//   slave  modport: arbiter side
//   master modport: requesters + memory side
interface dmem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker.
//   ereq_i[1:0]   - effective requests (port 1, port 0)
//   last_i        - port that won the previous grant
//   grant_valid_o - at least one request present
//   winner_o      - selected port; on a tie the port other than last_i wins
module rr_pick2
    import rv32_arb_pkg::*;
(
    input  logic [1:0] ereq_i,
    input  logic       last_i,
    output logic       grant_valid_o,
    output logic       winner_o
);

    always_comb begin
        grant_valid_o = |ereq_i;
        winner_o      = PORT_CORE;
        case (ereq_i)
            2'b01:   winner_o = PORT_CORE;
            2'b10:   winner_o = PORT_LOAD;
            2'b11:   winner_o = ~last_i;
            default: winner_o = PORT_CORE;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing a single-port synchronous-read
// data memory between the core (port 0) and the loader (port 1).
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - dmem_arbiter_if.slave: request/ack/rdata per port, memory controls, busy
// Each transaction: IDLE (grant + latch) -> ACCESS (memory cycle) -> RESP
// (capture mem_rdata) -> ack pulse in the following IDLE cycle.
module dmem_arbiter
    import rv32_arb_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [1:0]    ack_q, ack_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic [1:0]    ereq;
    logic          grant_valid;
    logic          winner;

    // A port is ignored during its own ack cycle so a requester that is
    // still dropping req is not granted a second time.
    assign ereq = {bus.req1 & ~ack_q[1], bus.req0 & ~ack_q[0]};

    rr_pick2 u_pick (
        .ereq_i        (ereq),
        .last_i        (last_q),
        .grant_valid_o (grant_valid),
        .winner_o      (winner)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        owner_d  = owner_q;
        last_d   = last_q;
        ack_d    = '0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_d = winner;
                    last_d  = winner;
                    we_d    = (winner == PORT_LOAD) ? bus.we1    : bus.we0;
                    addr_d  = (winner == PORT_LOAD) ? bus.addr1  : bus.addr0;
                    wdata_d = (winner == PORT_LOAD) ? bus.wdata1 : bus.wdata0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                ack_d[owner_q] = 1'b1;
                if (!we_q) begin
                    if (owner_q == PORT_LOAD) rdata1_d = bus.mem_rdata;
                    else                      rdata0_d = bus.mem_rdata;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            owner_q  <= PORT_CORE;
            last_q   <= PORT_LOAD;
            ack_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            ack_q    <= ack_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Address and data always reflect the latched request; only the write
    // enable is gated, so an async reset kills an in-flight write at once.
    assign bus.mem_we    = (state_q == ST_ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.ack0      = ack_q[0];
    assign bus.ack1      = ack_q[1];
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios followed by randomized two-port traffic
// checked against a transaction-level memory model.
module tb_dmem_arbiter;

    logic clk;
    logic reset;

    dmem_arbiter_if #(.AW(10), .DW(32)) bus ();

    dmem_arbiter #(.AW(10), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory with a side preload port.
    logic [31:0] mem [0:1023];
    logic        pl_en;
    logic [9:0]  pl_a;
    logic [31:0] pl_d;

    always @(posedge clk) begin
        if (pl_en)           mem[pl_a] <= pl_d;
        else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    int         we_cnt = 0;
    logic [9:0] we_addr = '0;
    always @(posedge clk) begin
        if (bus.mem_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= bus.mem_addr;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic drive(input bit p, input logic w, input logic [9:0] a, input logic [31:0] d);
        if (p) begin
            bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    // Waits (bounded) for the port's ack, checks the cycle count, drops req.
    task automatic wait_ack(input bit p, input int exp_n, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((p ? bus.ack1 : bus.ack0) !== 1'b1) && n < 15);
        chk({tag, "_lat"}, 32'(n), 32'(exp_n));
        if (p) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Randomized-phase model state
    logic [31:0] ref_mem [16];
    bit          pend [2];
    logic        rw [2];
    logic [9:0]  ra [2];
    logic [31:0] rd [2];
    int          age [2];
    int          nwr;
    int          w0;

    initial begin
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        pl_en = 0; pl_a = '0; pl_d = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ack0",  32'(bus.ack0), 32'd0);
        chk("rst_ack1",  32'(bus.ack1), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_we",    32'(bus.mem_we), 32'd0);
        chk("rst_rd0",   bus.rdata0, 32'd0);
        chk("rst_rd1",   bus.rdata1, 32'd0);
        chk("rst_maddr", 32'(bus.mem_addr), 32'd0);
        reset = 1'b0;

        // Single read on port 0
        preload(10'd5, 32'hDEADBEEF);
        @(negedge clk);
        drive(0, 1'b0, 10'd5, 32'd0);
        chk("t1_busy_c0", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("t1_busy_c1", 32'(bus.busy), 32'd1);
        chk("t1_we_c1",   32'(bus.mem_we), 32'd0);
        chk("t1_addr_c1", 32'(bus.mem_addr), 32'd5);
        @(negedge clk);
        chk("t1_busy_c2", 32'(bus.busy), 32'd1);
        chk("t1_we_c2",   32'(bus.mem_we), 32'd0);
        chk("t1_ack_c2",  32'(bus.ack0), 32'd0);
        @(negedge clk);
        chk("t1_ack_c3",  32'(bus.ack0), 32'd1);
        chk("t1_rdata",   bus.rdata0, 32'hDEADBEEF);
        chk("t1_busy_c3", 32'(bus.busy), 32'd0);
        bus.req0 = 1'b0;
        @(negedge clk);
        chk("t1_ack_c4",  32'(bus.ack0), 32'd0);

        // Write then read on port 1
        w0 = we_cnt;
        @(negedge clk);
        drive(1, 1'b1, 10'h3FF, 32'h12345678);
        wait_ack(1, 3, "t2w");
        chk("t2_we_pulses", 32'(we_cnt - w0), 32'd1);
        chk("t2_we_addr",   32'(we_addr), 32'h3FF);
        @(negedge clk);
        drive(1, 1'b0, 10'h3FF, 32'd0);
        wait_ack(1, 3, "t2r");
        chk("t2_rdata1", bus.rdata1, 32'h12345678);
        chk("t2_rdata0", bus.rdata0, 32'hDEADBEEF);

        // Contention, both held: ack0 at 3,9 and ack1 at 6,12
        preload(10'd1, 32'hA1A1A1A1);
        preload(10'd2, 32'hB2B2B2B2);
        @(negedge clk);
        drive(0, 1'b0, 10'd1, 32'd0);
        drive(1, 1'b0, 10'd2, 32'd0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk($sformatf("t3_ack0_c%0d", c), 32'(bus.ack0), 32'((c % 6) == 3));
            chk($sformatf("t3_ack1_c%0d", c), 32'(bus.ack1), 32'((c % 6) == 0));
            if (c == 3) chk("t3_rdata0", bus.rdata0, 32'hA1A1A1A1);
            if (c == 6) chk("t3_rdata1", bus.rdata1, 32'hB2B2B2B2);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        chk("t3_idle", 32'(bus.busy), 32'd0);

        // Input change after grant
        preload(10'd4, 32'hC4C4C4C4);
        preload(10'd9, 32'hC9C9C9C9);
        @(negedge clk);
        drive(0, 1'b0, 10'd4, 32'd0);
        @(negedge clk);
        bus.addr0 = 10'd9;
        #1;
        chk("t4_maddr", 32'(bus.mem_addr), 32'd4);
        wait_ack(0, 2, "t4");
        chk("t4_rdata0", bus.rdata0, 32'hC4C4C4C4);

        // Reset in the middle of a write
        preload(10'd7, 32'h00000077);
        @(negedge clk);
        drive(1, 1'b1, 10'd7, 32'h00000055);
        @(negedge clk);
        chk("t5_we_pre",  32'(bus.mem_we), 32'd1);
        chk("t5_addr_pre", 32'(bus.mem_addr), 32'd7);
        reset = 1'b1;
        #1;
        chk("t5_we",     32'(bus.mem_we), 32'd0);
        chk("t5_busy",   32'(bus.busy), 32'd0);
        chk("t5_ack1",   32'(bus.ack1), 32'd0);
        chk("t5_rd0",    bus.rdata0, 32'd0);
        chk("t5_rd1",    bus.rdata1, 32'd0);
        chk("t5_maddr",  32'(bus.mem_addr), 32'd0);
        chk("t5_mwdata", bus.mem_wdata, 32'd0);
        bus.req1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_mem7", mem[7], 32'h00000077);
        @(negedge clk);
        drive(0, 1'b0, 10'd1, 32'd0);
        drive(1, 1'b0, 10'd2, 32'd0);
        repeat (3) @(negedge clk);
        chk("t5_tie_ack0", 32'(bus.ack0), 32'd1);
        chk("t5_tie_ack1", 32'(bus.ack1), 32'd0);
        chk("t5_tie_rd0",  bus.rdata0, 32'hA1A1A1A1);
        bus.req0 = 1'b0;
        wait_ack(1, 3, "t5_p1");
        chk("t5_tie_rd1",  bus.rdata1, 32'hB2B2B2B2);

        // Request held through its own ack
        @(negedge clk);
        drive(0, 1'b0, 10'd5, 32'd0);
        repeat (3) @(negedge clk);
        chk("t6_ack_c3",  32'(bus.ack0), 32'd1);
        @(negedge clk);
        chk("t6_ack_c4",  32'(bus.ack0), 32'd0);
        chk("t6_busy_c4", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("t6_busy_c5", 32'(bus.busy), 32'd1);
        chk("t6_addr_c5", 32'(bus.mem_addr), 32'd5);
        bus.req0 = 1'b0;
        wait_ack(0, 2, "t6");
        chk("t6_rdata0", bus.rdata0, 32'hDEADBEEF);

        // Randomized traffic on addresses 0..15
        for (int a = 0; a < 16; a++) begin
            ref_mem[a] = $urandom;
            preload(10'(a), ref_mem[a]);
        end
        pend[0] = 0; pend[1] = 0;
        age[0] = 0; age[1] = 0;
        nwr = 0;
        w0 = we_cnt;
        for (int cyc = 0; cyc < 460; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                logic ak;
                ak = (p == 0) ? bus.ack0 : bus.ack1;
                if (pend[p]) begin
                    age[p]++;
                    if (ak === 1'b1) begin
                        chk("rnd_lat", 32'(age[p] >= 3 && age[p] <= 6), 32'd1);
                        if (!rw[p]) begin
                            chk("rnd_rdata", (p == 0) ? bus.rdata0 : bus.rdata1, ref_mem[ra[p][3:0]]);
                        end else begin
                            ref_mem[ra[p][3:0]] = rd[p];
                            nwr++;
                        end
                        pend[p] = 0;
                        if (p == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
                    end else if (age[p] > 12) begin
                        chk("rnd_timeout", 32'(age[p]), 32'd6);
                        pend[p] = 0;
                        if (p == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
                    end
                end else if (cyc < 400 && $urandom_range(0, 2) == 0) begin
                    rw[p]   = 1'($urandom_range(0, 1));
                    ra[p]   = 10'($urandom_range(0, 15));
                    rd[p]   = $urandom;
                    age[p]  = 0;
                    pend[p] = 1;
                    drive(p[0], rw[p], ra[p], rd[p]);
                end
            end
        end
        chk("rnd_drained", 32'(pend[0] || pend[1]), 32'd0);
        chk("rnd_we_pulses", 32'(we_cnt - w0), 32'(nwr));
        chk("rnd_idle", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port, synchronous-read data memory (`dmem`) between the rv32 core's load/store path and a program/debug loader port. Each request is captured into a private register set, presented to the memory for exactly one cycle, and completed with a one-cycle acknowledge carrying registered read data. Fairness between the two ports is round-robin. The block sits between the core/loader and `dmem`, replacing the core's direct connection to that memory.

## Interface
- `AW`, default 10, word-address width (matches the `dmem` address).
- `DW`, default 32, data width.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  request. Port 0 is the core; port 1 is the loader.
- `we0`, `we1`  in  1  1 = write, 0 = read. Qualified by `req`.
- `addr0`, `addr1`  in  AW  word address.
- `wdata0`, `wdata1`  in  DW  write data.
- `ack0`, `ack1`  out  1  one-cycle completion pulse, registered.
- `rdata0`, `rdata1`  out  DW  registered read data. Valid while `ack` is high and held until that port's next read completes.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data. Valid in the cycle after the address edge.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- FSM states: IDLE → ACCESS → RESP → IDLE.
- Effective request: `ereq_i = req_i & ~ack_i`. A port whose ack is high in a cycle is ignored in that cycle.
- **IDLE:**
  - If any `ereq` is high, select a winner and latch the winner's `we`, `addr` and `wdata` into `we_q`, `addr_q` and `wdata_q`.
  - Store the winner in `owner`, set `last <= owner`, and go to ACCESS.
  - Otherwise stay in IDLE.
- **Winner selection:**
  - If only one port requests, that port wins.
  - If both request, the port not equal to `last` wins.
- **ACCESS:**
  - `mem_addr = addr_q`, `mem_wdata = wdata_q`, `mem_we = we_q`.
  - `mem_we` is high only in this state.
  - Go to RESP.
- **RESP:**
  - At the exiting edge, set `ack_owner <= 1`.
  - If `!we_q`, set `rdata_owner <= mem_rdata`; writes leave `rdata` unchanged.
  - Go to IDLE.
- `ack` is a registered pulse that is cleared on the following edge.
- Requester rule: hold `req`, `we`, `addr` and `wdata` stable until grant, and drop `req` in the ack cycle. Inputs are sampled only in the IDLE grant cycle. Later input changes have no effect on the transaction in flight.
- Requests arriving while busy wait. No request is dropped.
- `mem_addr` and `mem_wdata` show the latched values in every state. Only `mem_we` is state-gated.

## Timing
- **Single request:** req high in cycle 0 (IDLE), memory access in cycle 1, `mem_rdata` sampled in cycle 2, `ack`/`rdata` in cycle 3.
  - Latency is 3 cycles.
  - Peak throughput is one transaction per 3 cycles.
- **Both requesting from cycle 0, `last` = 1:**
  - Port 0 is acked in cycle 3.
  - Port 1 is granted in cycle 3 and acked in cycle 6.
  - Alternation continues while both hold their requests.
- **Back-to-back on one port:** a new request asserted in the cycle after its ack is granted in that cycle.
- **Reset (asynchronous, any cycle, including mid-transaction):**
  - State goes to IDLE.
  - `ack0`, `ack1`, `mem_we`, `busy` = 0.
  - `rdata0`, `rdata1`, `addr_q`, `wdata_q`, `we_q` = 0.
  - `owner` = 0, `last` = 1, so port 0 wins the first tie.
  - An in-flight write is aborted with `mem_we` falling immediately. It is not retried.
- **Width rules:** addresses and data pass through unmodified. There is no wrap or offset arithmetic.

## Structure
- Package `rv32_arb_pkg`:
  - State encoding: IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2. The unused code returns to IDLE.
  - Port index constants: `PORT_CORE` = 0, `PORT_LOAD` = 1.
- Sub-module `rr_pick2`: a combinational 2-way round-robin picker with inputs (`ereq[1:0]`, `last`) and outputs (`grant_valid`, `winner`). The FSM, latches and output registers stay in `dmem_arbiter`.

## Test plan
- **Single read on port 0:** preload mem[5] = 32'hDEADBEEF, pulse req0 with we0 = 0 and addr0 = 5.
  - `mem_we` = 0 throughout.
  - `ack0` high in cycle 3 with `rdata0` = 32'hDEADBEEF.
  - `busy` high in cycles 1–2.
- **Write then read on port 1:** write 32'h12345678 to address 10'h3FF, then read the same address.
  - `mem_we` high for exactly one cycle with `mem_addr` = 10'h3FF.
  - The read returns 32'h12345678 on `rdata1`.
  - `rdata0` is unchanged.
- **Contention:** both ports read (addr0 = 1, addr1 = 2) from cycle 0 and hold until acked.
  - `ack0` at cycle 3, `ack1` at cycle 6.
  - With both held continuously, grants alternate 0, 1, 0, 1.
- **Input change after grant:** change `addr0` from 4 to 9 in cycle 1.
  - `mem_addr` stays 4.
  - `rdata0` returns mem[4].
- **Reset mid-write:** assert `reset` during ACCESS of a write to address 7.
  - `mem_we` falls immediately, all outputs are 0, and mem[7] keeps its old value.
  - After release, a tie is won by port 0.
- **Ack-cycle hold:** port 0 keeps `req0` high through its ack.
  - No grant is issued in the ack cycle.
  - A new grant is issued in the following cycle.
